// File: rtl/scrambler_pkg.sv
// Shared types and constants for the keystream XOR stage and its output FIFO.
package scrambler_pkg;

    // Payload and keystream width, tied to the poly-select mux output.
    localparam int DATA_W = 16;

    // Output FIFO depth.
    localparam int FIFO_DEPTH = 2;

    // Framing state: waiting for a first word, or inside a multi-word frame.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } scr_state_e;

    // One FIFO slot: scrambled word plus its end-of-frame marker.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } fifo_entry_t;

endpackage

// File: rtl/scr_out_fifo2.sv
// Two-entry output FIFO. The head slot drives the outputs straight from a
// register, and the push-permission flag is also registered, so nothing on the
// downstream ready path reaches the upstream ready.
module scr_out_fifo2
    import scrambler_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_last,
    output logic              head_valid,
    output logic              can_push
);

    fifo_entry_t head_r;
    fifo_entry_t tail_r;
    fifo_entry_t push_entry_s;
    logic [1:0]  count_r;
    logic [1:0]  count_next_s;
    logic        can_push_r;
    logic        full_s;
    logic        empty_s;
    logic        pop_eff_s;
    logic        push_eff_s;

    assign full_s  = (count_r == 2'd2);
    assign empty_s = (count_r == 2'd0);

    // Qualify push/pop against occupancy and compute the next occupancy.
    always_comb begin
        push_entry_s      = '{data: push_data, last: push_last};
        pop_eff_s         = pop && !empty_s;
        push_eff_s        = push && (!full_s || pop_eff_s);
        count_next_s      = count_r;
        case ({push_eff_s, pop_eff_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Occupancy counter and the registered "room available" flag; the flag is
    // held low throughout reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r    <= 2'd0;
            can_push_r <= 1'b0;
        end else begin
            count_r    <= count_next_s;
            can_push_r <= (count_next_s != 2'd2);
        end
    end

    // Slot storage: the head always holds the oldest entry; a pop from a full
    // FIFO shifts the tail forward, and a simultaneous push refills behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= '{data: {DATA_W{1'b0}}, last: 1'b0};
            tail_r <= '{data: {DATA_W{1'b0}}, last: 1'b0};
        end else if (pop_eff_s) begin
            if (count_r == 2'd2) begin
                head_r <= tail_r;
                if (push_eff_s) begin
                    tail_r <= push_entry_s;
                end
            end else if (push_eff_s) begin
                head_r <= push_entry_s;
            end
        end else if (push_eff_s) begin
            if (empty_s) begin
                head_r <= push_entry_s;
            end else begin
                tail_r <= push_entry_s;
            end
        end
    end

    assign head_data  = head_r.data;
    assign head_last  = head_r.last;
    assign head_valid = !empty_s;
    assign can_push   = can_push_r;

endmodule

// File: rtl/scramble_xor_stage.sv
// Keystream XOR stage: XORs each accepted payload word with the current key,
// strobes key_adv so the upstream selector steps, frames the traffic with a
// maximum-length guard and buffers results in a 2-entry output FIFO.
module scramble_xor_stage #(
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              bypass,
    input  logic [DATA_W-1:0] key_in,
    output logic              key_adv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [7:0]        frame_cnt,
    output logic              len_err
);

    import scrambler_pkg::*;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    scr_state_e        state_r;
    scr_state_e        state_next_s;
    logic              bypass_q_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic [CNT_W-1:0]  word_cnt_next_s;
    logic [7:0]        frame_cnt_r;
    logic              len_err_r;
    logic              accept_s;
    logic              first_word_s;
    logic              last_eff_s;
    logic              forced_last_s;
    logic              frame_bypass_s;
    logic [DATA_W-1:0] push_data_s;
    logic              fifo_can_push_s;
    logic              fifo_head_valid_s;
    logic              pop_s;

    assign accept_s = in_valid && fifo_can_push_s;
    assign pop_s    = fifo_head_valid_s && out_ready;

    // Framing state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, effective last, bypass selection and scrambled payload.
    always_comb begin
        state_next_s    = state_r;
        first_word_s    = (state_r == ST_IDLE);
        word_cnt_next_s = first_word_s ? CNT_W'(1) : (word_cnt_r + CNT_W'(1));
        last_eff_s      = in_last || (word_cnt_next_s == MAX_CNT);
        forced_last_s   = accept_s && last_eff_s && !in_last;
        frame_bypass_s  = first_word_s ? bypass : bypass_q_r;
        push_data_s     = frame_bypass_s ? in_data : (in_data ^ key_in);
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !last_eff_s) begin
                    state_next_s = ST_FRAME;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (accept_s && last_eff_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_FRAME;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Per-frame bookkeeping: bypass latched on the first word, word counter
    // held after frame end, completed-frame counter and sticky length error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_q_r  <= 1'b0;
            word_cnt_r  <= {CNT_W{1'b0}};
            frame_cnt_r <= 8'd0;
            len_err_r   <= 1'b0;
        end else if (accept_s) begin
            word_cnt_r <= word_cnt_next_s;
            if (first_word_s) begin
                bypass_q_r <= bypass;
            end
            if (last_eff_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
            if (forced_last_s) begin
                len_err_r <= 1'b1;
            end
        end
    end

    scr_out_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept_s),
        .push_data  (push_data_s),
        .push_last  (last_eff_s),
        .pop        (pop_s),
        .head_data  (out_data),
        .head_last  (out_last),
        .head_valid (fifo_head_valid_s),
        .can_push   (fifo_can_push_s)
    );

    // The key is consumed exactly when a word is accepted, bypass or not.
    assign key_adv   = accept_s;
    assign in_ready  = fifo_can_push_s;
    assign out_valid = fifo_head_valid_s;
    assign word_cnt  = word_cnt_r;
    assign frame_cnt = frame_cnt_r;
    assign len_err   = len_err_r;

endmodule

// File: tb/tb_scramble_xor_stage.sv
// Self-checking bench for scramble_xor_stage with a queue-based reference model.
module tb_scramble_xor_stage;

    localparam int DW   = 16;
    localparam int MAXW = 4;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = 16'h0000;
    logic          in_last = 1'b0;
    logic          bypass = 1'b0;
    logic [DW-1:0] key_in = 16'h0000;
    logic          key_adv;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [CW-1:0] word_cnt;
    logic [7:0]    frame_cnt;
    logic          len_err;

    always #5 clk = ~clk;

    scramble_xor_stage #(.DATA_W(DW), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .bypass(bypass), .key_in(key_in),
        .key_adv(key_adv), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .word_cnt(word_cnt),
        .frame_cnt(frame_cnt), .len_err(len_err)
    );

    typedef struct {
        logic [15:0] d;
        logic        l;
    } ent_t;

    int   tests = 0;
    int   fails = 0;
    ent_t q[$];
    bit   in_frame_m, byp_m, len_err_m, ready_m;
    int   pos_m, fc_m;
    bit   acc_m, kadv_obs;
    int   kadv_obs_cnt = 0;

    task automatic model_clear();
        q.delete();
        in_frame_m = 1'b0; byp_m = 1'b0; len_err_m = 1'b0; ready_m = 1'b0;
        pos_m = 0; fc_m = 0;
    endtask

    // One clock: sample pre-edge, advance the reference model at the edge.
    task automatic tick();
        ent_t e;
        bit   pop_m;
        #2;
        acc_m    = in_valid && ready_m;
        pop_m    = (q.size() > 0) && out_ready;
        kadv_obs = key_adv;
        if (kadv_obs) kadv_obs_cnt++;
        @(posedge clk);
        if (pop_m) e = q.pop_front();
        if (acc_m) begin
            if (!in_frame_m) begin pos_m = 1; byp_m = bypass; end
            else pos_m++;
            e.l = in_last || (pos_m == MAXW);
            if (e.l && !in_last) len_err_m = 1'b1;
            e.d = byp_m ? in_data : (in_data ^ key_in);
            q.push_back(e);
            in_frame_m = !e.l;
            if (e.l) fc_m = (fc_m + 1) % 256;
        end
        ready_m = (q.size() != 2);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; in_valid = 1'b0;
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; #1; rst = 1'b1;
        in_valid = 1'b1; in_data = 16'h1234; key_in = 16'h4321;
        model_clear();
        #2;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        tests++; if (key_adv !== 1'b0) begin fails++; $display("FAIL reset_key_adv got %b exp 0", key_adv); end
        tests++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_last !== 1'b0) begin
            fails++; $display("FAIL reset_out got v=%b d=%h l=%b exp 0/0000/0", out_valid, out_data, out_last); end
        tests++; if (word_cnt !== 16'd0 || frame_cnt !== 8'd0 || len_err !== 1'b0) begin
            fails++; $display("FAIL reset_counters got wc=%0d fc=%0d le=%b exp 0/0/0", word_cnt, frame_cnt, len_err); end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_single();
        int k0;
        k0 = kadv_obs_cnt;
        out_ready = 1'b1; bypass = 1'b0;
        in_valid = 1'b1; in_data = 16'hA5A5; key_in = 16'h0F0F; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_data !== 16'hAAAA || out_last !== 1'b1) begin
            fails++; $display("FAIL single_out got v=%b d=%h l=%b exp 1/aaaa/1", out_valid, out_data, out_last); end
        tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL single_frame_cnt got %0d exp 1", frame_cnt); end
        tick();
        tests++; if (kadv_obs_cnt - k0 !== 1) begin fails++; $display("FAIL single_key_adv got %0d exp 1", kadv_obs_cnt - k0); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_w[8];
        int k0;
        k0 = kadv_obs_cnt;
        out_ready = 1'b1; bypass = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom); key_in = 16'(i + 1);
            in_last = (i == 7);
            exp_w[i] = in_data ^ key_in;
            tick();
            tests++; if (out_valid !== 1'b1 || out_data !== exp_w[i]) begin
                fails++; $display("FAIL stream_word[%0d] got v=%b d=%h exp 1/%h", i, out_valid, out_data, exp_w[i]); end
            tests++; if (q.size() > 0 && out_last !== q[0].l) begin
                fails++; $display("FAIL stream_last[%0d] got %b exp %b", i, out_last, q[0].l); end
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        tests++; if (kadv_obs_cnt - k0 !== 8) begin fails++; $display("FAIL stream_key_adv got %0d exp 8", kadv_obs_cnt - k0); end
    endtask

    task automatic test_backpressure();
        logic [15:0] d[4], k[4];
        int idx, n, k0, budget;
        for (int i = 0; i < 4; i++) begin d[i] = 16'($urandom); k[i] = 16'($urandom); end
        k0 = kadv_obs_cnt; idx = 0; n = 0;
        out_ready = 1'b0; bypass = 1'b0; in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_data = d[idx]; key_in = k[idx];
            tick();
            if (acc_m) idx++;
        end
        tests++; if (kadv_obs_cnt - k0 !== 2) begin fails++; $display("FAIL bp_key_adv got %0d exp 2", kadv_obs_cnt - k0); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        out_ready = 1'b1; budget = 0;
        while ((idx < 4 || n < 4) && budget < 30) begin
            in_valid = (idx < 4);
            if (idx < 4) begin in_data = d[idx]; key_in = k[idx]; end
            if (out_valid && n < 4) begin
                tests++; if (out_data !== (d[n] ^ k[n])) begin
                    fails++; $display("FAIL bp_order[%0d] got %h exp %h", n, out_data, d[n] ^ k[n]); end
                n++;
            end
            tick();
            if (acc_m) idx++;
            budget++;
        end
        in_valid = 1'b0;
        tests++; if (n !== 4) begin fails++; $display("FAIL bp_drain got %0d words exp 4", n); end
        tests++; if (kadv_obs_cnt - k0 !== 4) begin fails++; $display("FAIL bp_key_adv_total got %0d exp 4", kadv_obs_cnt - k0); end
    endtask

    task automatic test_bypass();
        logic [15:0] exp_w[5];
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom); key_in = 16'($urandom | 1);
            bypass  = (i == 0);
            in_last = (i == 2) || (i == 4);
            exp_w[i] = (i < 3) ? in_data : (in_data ^ key_in);
            tick();
            tests++; if (out_valid !== 1'b1 || out_data !== exp_w[i] || out_last !== in_last) begin
                fails++; $display("FAIL bypass_word[%0d] got v=%b d=%h l=%b exp 1/%h/%b",
                                  i, out_valid, out_data, out_last, exp_w[i], in_last); end
        end
        in_valid = 1'b0; in_last = 1'b0; bypass = 1'b0;
        tick();
    endtask

    task automatic test_len_guard();
        int exp_wc;
        apply_reset();
        out_ready = 1'b1; bypass = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom); key_in = 16'($urandom);
            tick();
            exp_wc = (i < 4) ? i + 1 : i - 3;
            tests++; if (word_cnt !== 16'(exp_wc)) begin fails++; $display("FAIL len_word_cnt[%0d] got %0d exp %0d", i, word_cnt, exp_wc); end
            tests++; if (out_last !== (i == 3)) begin fails++; $display("FAIL len_out_last[%0d] got %b exp %b", i, out_last, (i == 3)); end
            tests++; if (len_err !== (i >= 3)) begin fails++; $display("FAIL len_err[%0d] got %b exp %b", i, len_err, (i >= 3)); end
        end
        in_valid = 1'b0;
        tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL len_frame_cnt got %0d exp 1", frame_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_last = 1'b0; bypass = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom); key_in = 16'($urandom);
            tick();
        end
        rst = 1'b1; #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_out_valid got %b exp 0", out_valid); end
        tests++; if (word_cnt !== 16'd0 || frame_cnt !== 8'd0 || len_err !== 1'b0) begin
            fails++; $display("FAIL rstmid_counters got wc=%0d fc=%0d le=%b exp 0/0/0", word_cnt, frame_cnt, len_err); end
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom); key_in = 16'($urandom); in_last = (i == 2);
            tick();
            tests++; if (out_valid !== 1'b1 || out_data !== q[q.size()-1].d) begin
                fails++; $display("FAIL rstmid_word[%0d] got v=%b d=%h", i, out_valid, out_data); end
        end
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        tests++; if (frame_cnt !== 8'd1) begin fails++; $display("FAIL rstmid_frame_cnt got %0d exp 1", frame_cnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            key_in    = 16'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            bypass    = $urandom_range(0, 1) != 0;
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            tests++; if (kadv_obs !== acc_m) begin fails++; $display("FAIL rnd_key_adv[%0d] got %b exp %b", c, kadv_obs, acc_m); end
            tests++; if (out_valid !== (q.size() > 0) || in_ready !== ready_m) begin
                fails++; $display("FAIL rnd_flags[%0d] got ov=%b ir=%b exp %b/%b", c, out_valid, in_ready, (q.size() > 0), ready_m); end
            if (q.size() > 0) begin
                tests++; if (out_data !== q[0].d || out_last !== q[0].l) begin
                    fails++; $display("FAIL rnd_out[%0d] got %h/%b exp %h/%b", c, out_data, out_last, q[0].d, q[0].l); end
            end
            tests++; if (word_cnt !== 16'(pos_m) || frame_cnt !== 8'(fc_m) || len_err !== len_err_m) begin
                fails++; $display("FAIL rnd_counters[%0d] got wc=%0d fc=%0d le=%b exp %0d/%0d/%b",
                                  c, word_cnt, frame_cnt, len_err, pos_m, fc_m, len_err_m); end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_bypass();
        test_len_guard();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule
